// File: rtl/conv_kxk_param_if.sv
// Column-stream, coefficient-load and result signals of conv_kxk_param.
// The master side drives columns and coefficients; the slave side is the filter.
interface conv_kxk_param_if #(
  parameter int K      = 3,
  parameter int DATA_W = 8,
  parameter int COEF_W = 16,
  parameter int SUM_W  = DATA_W + COEF_W + $clog2(K * K) + 1
);
  logic                     i_valid;
  logic                     i_sof;
  logic [K*DATA_W-1:0]      i_data;
  logic                     coef_we;
  logic [5:0]               coef_addr;
  logic signed [COEF_W-1:0] coef_data;
  logic                     coef_commit;
  logic                     o_valid;
  logic signed [SUM_W-1:0]  o_sum;
  logic [DATA_W-1:0]        o_pix;

  modport master (
    output i_valid, i_sof, i_data, coef_we, coef_addr, coef_data, coef_commit,
    input  o_valid, o_sum, o_pix
  );

  modport slave (
    input  i_valid, i_sof, i_data, coef_we, coef_addr, coef_data, coef_commit,
    output o_valid, o_sum, o_pix
  );
endinterface

// File: rtl/conv_kxk_param.sv
// K x K streaming convolution: column window, double-buffered coefficients,
// one multiply stage, pipelined adder tree, then round/shift/saturate.
module conv_kxk_param #(
  parameter int K      = 3,
  parameter int DATA_W = 8,
  parameter int COEF_W = 16,
  parameter int SHIFT  = 0
) (
  input  logic           clk,
  input  logic           reset,
  conv_kxk_param_if.slave bus
);
  localparam int KK     = K * K;
  localparam int LVL    = $clog2(KK);
  localparam int NLEAF  = 1 << LVL;
  localparam int SUM_W  = DATA_W + COEF_W + LVL + 1;
  localparam int LAT    = 3 + LVL;
  localparam int PW     = COEF_W + DATA_W + 1;
  localparam int CTR    = (K / 2) * K + K / 2;
  localparam int FILL_W = $clog2(K + 1);
  localparam logic signed [COEF_W-1:0] CRST    = COEF_W'(2 ** SHIFT);
  localparam logic signed [SUM_W:0]    RND     = (SUM_W + 1)'((2 ** SHIFT) / 2);
  localparam logic signed [SUM_W:0]    PIX_MAX = (SUM_W + 1)'((2 ** DATA_W) - 1);

  logic [DATA_W-1:0]        win_q  [K][K];
  logic signed [COEF_W-1:0] shad_q [KK];
  logic signed [COEF_W-1:0] act_q  [KK];
  logic signed [SUM_W-1:0]  leaf_d [NLEAF];
  logic signed [SUM_W-1:0]  tree_q [LVL+1][NLEAF];
  logic [FILL_W-1:0]        fill_q, fill_d;
  logic                     take_d;
  logic [LAT-1:0]           vld_q;
  logic signed [SUM_W-1:0]  sum_q;
  logic [DATA_W-1:0]        pix_q, pix_d;
  logic signed [SUM_W:0]    rnd_sum, shifted;

  always_comb begin
    fill_d = fill_q;
    take_d = 1'b0;
    if (bus.i_valid) begin
      if (bus.i_sof) begin
        fill_d = FILL_W'(1);
      end else if (fill_q != FILL_W'(K)) begin
        fill_d = fill_q + 1'b1;
      end
      take_d = (fill_d == FILL_W'(K));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fill_q <= '0;
      for (int unsigned r = 0; r < K; r++)
        for (int unsigned c = 0; c < K; c++)
          win_q[r][c] <= '0;
    end else begin
      fill_q <= fill_d;
      if (bus.i_valid) begin
        for (int unsigned r = 0; r < K; r++) begin
          win_q[r][0] <= bus.i_data[(K-r)*DATA_W-1 -: DATA_W];
          for (int unsigned c = 1; c < K; c++)
            win_q[r][c] <= win_q[r][c-1];
        end
      end
    end
  end

  // Commit copies the pre-write shadow contents, so a same-cycle write stays shadow-only.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < KK; i++) begin
        shad_q[i] <= (i == CTR) ? CRST : '0;
        act_q[i]  <= (i == CTR) ? CRST : '0;
      end
    end else begin
      for (int unsigned i = 0; i < KK; i++) begin
        if (bus.coef_we && bus.coef_addr == 6'(i))
          shad_q[i] <= bus.coef_data;
        if (bus.coef_commit)
          act_q[i] <= shad_q[i];
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NLEAF; i++)
      leaf_d[i] = '0;
    for (int unsigned r = 0; r < K; r++)
      for (int unsigned c = 0; c < K; c++)
        leaf_d[r*K+c] = SUM_W'(PW'(act_q[r*K+c]) * PW'($signed({1'b0, win_q[r][c]})));
  end

  // Level 0 holds the products; each higher level halves the live entry count.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned l = 0; l <= LVL; l++)
        for (int unsigned i = 0; i < NLEAF; i++)
          tree_q[l][i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NLEAF; i++)
        tree_q[0][i] <= leaf_d[i];
      for (int unsigned l = 1; l <= LVL; l++) begin
        for (int unsigned i = 0; i < NLEAF; i++)
          tree_q[l][i] <= '0;
        for (int unsigned i = 0; i < (NLEAF >> l); i++)
          tree_q[l][i] <= tree_q[l-1][2*i] + tree_q[l-1][2*i+1];
      end
    end
  end

  always_comb begin
    rnd_sum = {tree_q[LVL][0][SUM_W-1], tree_q[LVL][0]} + RND;
    shifted = rnd_sum >>> SHIFT;
    if (shifted[SUM_W])
      pix_d = '0;
    else if (shifted > PIX_MAX)
      pix_d = '1;
    else
      pix_d = shifted[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      sum_q <= '0;
      pix_q <= '0;
    end else begin
      vld_q <= {vld_q[LAT-2:0], take_d};
      sum_q <= tree_q[LVL][0];
      pix_q <= pix_d;
    end
  end

  assign bus.o_valid = vld_q[LAT-1];
  assign bus.o_sum   = sum_q;
  assign bus.o_pix   = pix_q;
endmodule

// File: tb/tb_conv_kxk_param.sv
// Scoreboard bench for conv_kxk_param: two instances (SHIFT 0 and 4) share one
// stimulus stream; a window/bank model predicts each result and its arrival cycle.
module tb_conv_kxk_param;
  localparam int K   = 3;
  localparam int KK  = 9;
  localparam int LAT = 7;
  localparam int SH0 = 0;
  localparam int SH1 = 4;

  typedef struct {
    longint sum0;
    longint sum1;
    int     pix0;
    int     pix1;
    longint cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_valid = 1'b0;
  logic        i_sof = 1'b0;
  logic [23:0] i_data = '0;
  logic        coef_we = 1'b0;
  logic [5:0]  coef_addr = '0;
  logic signed [15:0] coef_data = '0;
  logic        coef_commit = 1'b0;

  longint cyc = 0;
  logic   rst_smp = 1'b0;
  logic   done = 1'b0;
  int     total = 0;
  int     bad = 0;

  exp_t        sbq [$];
  logic [23:0] hist [$];
  int          fill;
  int          shad [2][KK];
  int          act  [2][KK];

  conv_kxk_param_if #(.K(K), .DATA_W(8), .COEF_W(16)) b0 ();
  conv_kxk_param_if #(.K(K), .DATA_W(8), .COEF_W(16)) b1 ();

  assign b0.i_valid = i_valid;      assign b1.i_valid = i_valid;
  assign b0.i_sof = i_sof;          assign b1.i_sof = i_sof;
  assign b0.i_data = i_data;        assign b1.i_data = i_data;
  assign b0.coef_we = coef_we;      assign b1.coef_we = coef_we;
  assign b0.coef_addr = coef_addr;  assign b1.coef_addr = coef_addr;
  assign b0.coef_data = coef_data;  assign b1.coef_data = coef_data;
  assign b0.coef_commit = coef_commit;
  assign b1.coef_commit = coef_commit;

  conv_kxk_param #(.K(K), .DATA_W(8), .COEF_W(16), .SHIFT(SH0)) dut0 (
    .clk(clk), .reset(reset), .bus(b0.slave));
  conv_kxk_param #(.K(K), .DATA_W(8), .COEF_W(16), .SHIFT(SH1)) dut1 (
    .clk(clk), .reset(reset), .bus(b1.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rst_smp <= reset;

  function automatic int pix_of(longint s, int sh);
    longint v;
    v = (s + ((longint'(1) << sh) >> 1)) >>> sh;
    if (v < 0) return 0;
    if (v > 255) return 255;
    return int'(v);
  endfunction

  function automatic longint conv(int d);
    longint s = 0;
    logic [23:0] col;
    int px;
    for (int c = 0; c < K; c++) begin
      col = hist[c];
      for (int r = 0; r < K; r++) begin
        px = int'(col[(K-1-r)*8 +: 8]);
        s += longint'(act[d][r*K+c]) * px;
      end
    end
    return s;
  endfunction

  task automatic bank_reset();
    for (int i = 0; i < KK; i++) begin
      shad[0][i] = (i == 4) ? (1 << SH0) : 0;
      shad[1][i] = (i == 4) ? (1 << SH1) : 0;
      act[0][i]  = shad[0][i];
      act[1][i]  = shad[1][i];
    end
  endtask

  task automatic model_step();
    exp_t e;
    longint t = cyc;
    if (reset) begin
      while (sbq.size() > 0 && sbq[$].cyc > t) void'(sbq.pop_back());
      fill = 0;
      hist.delete();
      for (int i = 0; i < K; i++) hist.push_back(24'h0);
      bank_reset();
      return;
    end
    if (coef_commit)
      for (int i = 0; i < KK; i++) begin
        act[0][i] = shad[0][i];
        act[1][i] = shad[1][i];
      end
    if (i_valid) begin
      hist.push_front(i_data);
      void'(hist.pop_back());
      fill = i_sof ? 1 : ((fill < K) ? fill + 1 : K);
      if (fill == K) begin
        e.sum0 = conv(0);
        e.sum1 = conv(1);
        e.pix0 = pix_of(e.sum0, SH0);
        e.pix1 = pix_of(e.sum1, SH1);
        e.cyc  = t + LAT;
        sbq.push_back(e);
      end
    end
    if (coef_we && int'(coef_addr) < KK) begin
      shad[0][coef_addr] = int'(coef_data);
      shad[1][coef_addr] = int'(coef_data);
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    i_valid = 1'b0; i_sof = 1'b0; coef_we = 1'b0; coef_commit = 1'b0; reset = 1'b0;
  endtask

  task automatic set_col(int p0, int p1, int p2);
    i_valid = 1'b1;
    i_data = {8'(p0), 8'(p1), 8'(p2)};
  endtask

  task automatic feed(int p0, int p1, int p2, bit sof);
    set_col(p0, p1, p2);
    i_sof = sof;
    step();
  endtask

  task automatic set_wr(int a, int v);
    coef_we = 1'b1;
    coef_addr = 6'(a);
    coef_data = 16'(v);
  endtask

  task automatic wr(int a, int v);
    set_wr(a, v);
    step();
  endtask

  task automatic idle(int n);
    repeat (n) step();
  endtask

  task automatic chk(string nm, longint a, longint e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, a, e);
    end
  endtask

  always @(negedge clk) begin
    bit ev;
    ev = (sbq.size() > 0) && (sbq[0].cyc == cyc);
    if (rst_smp) begin
      chk("rst_valid0", longint'(b0.o_valid), 0);
      chk("rst_sum0", longint'(b0.o_sum), 0);
      chk("rst_pix1", longint'(b1.o_pix), 0);
      chk("rst_sum1", longint'(b1.o_sum), 0);
    end else begin
      if (ev || b0.o_valid) chk("valid0", longint'(b0.o_valid), longint'(ev));
      if (ev || b1.o_valid) chk("valid1", longint'(b1.o_valid), longint'(ev));
      if (ev && b0.o_valid) begin
        chk("sum0", longint'(b0.o_sum), sbq[0].sum0);
        chk("pix0", longint'(b0.o_pix), longint'(sbq[0].pix0));
      end
      if (ev && b1.o_valid) begin
        chk("sum1", longint'(b1.o_sum), sbq[0].sum1);
        chk("pix1", longint'(b1.o_pix), longint'(sbq[0].pix1));
      end
    end
    if (ev) void'(sbq.pop_front());
    if (done) begin
      chk("drained", longint'(sbq.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  initial begin
    reset = 1'b1;
    step();
    reset = 1'b1;
    step();
    reset = 1'b1;
    step();

    // identity kernel and fill
    feed(10, 20, 30, 0);
    feed(40, 50, 60, 0);
    feed(70, 80, 90, 0);
    idle(10);

    // sharpen kernel on flat input
    for (int i = 0; i < KK; i++) wr(i, (i == 4) ? 9 : -1);
    coef_commit = 1'b1;
    step();
    repeat (6) feed(100, 100, 100, 0);
    idle(10);

    // saturation, both directions
    feed(0, 0, 0, 1);
    feed(0, 255, 0, 0);
    feed(0, 0, 0, 0);
    feed(255, 255, 255, 1);
    feed(255, 0, 255, 0);
    feed(255, 255, 255, 0);
    idle(10);

    // commit boundary on a continuous stream
    repeat (4) feed(100, 100, 100, 0);
    for (int i = 0; i < KK; i++) begin
      set_wr(i, 0);
      set_col(100, 100, 100);
      step();
    end
    coef_commit = 1'b1;
    set_col(100, 100, 100);
    step();
    repeat (4) feed(100, 100, 100, 0);
    idle(10);

    // same-cycle write and commit: the write must not be committed
    set_wr(4, 1);
    coef_commit = 1'b1;
    step();
    repeat (3) feed(100, 100, 100, 0);
    coef_commit = 1'b1;
    step();
    feed(1, 2, 3, 0);
    idle(1);
    feed(4, 5, 6, 0);
    idle(2);
    feed(7, 8, 9, 0);
    repeat (2) feed(11, 22, 33, 0);
    feed(44, 55, 66, 1);
    repeat (4) feed(77, 88, 99, 0);
    idle(10);

    // ignored addresses
    wr(9, 500);
    wr(63, -500);
    coef_commit = 1'b1;
    step();
    repeat (4) feed(12, 34, 56, 0);

    // reset mid-stream, then identity at pixel 200
    repeat (5) feed(100, 100, 100, 0);
    reset = 1'b1;
    set_col(100, 100, 100);
    step();
    repeat (4) feed(200, 200, 200, 0);
    idle(10);

    // coefficient extremes with full-scale pixels
    for (int i = 0; i < KK; i++) wr(i, -32768);
    coef_commit = 1'b1;
    step();
    repeat (4) feed(255, 255, 255, 0);
    for (int i = 0; i < KK; i++) wr(i, 32767);
    coef_commit = 1'b1;
    step();
    repeat (4) feed(255, 255, 255, 0);
    repeat (3) feed(0, 0, 0, 0);
    idle(10);

    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 9) < 7) begin
        i_valid = 1'b1;
        i_data = 24'($urandom);
        i_sof = ($urandom_range(0, 15) == 0);
      end
      if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 7))
          0: set_wr(int'($urandom_range(0, 15)), -32768);
          1: set_wr(int'($urandom_range(0, 15)), 32767);
          default: set_wr(int'($urandom_range(0, 15)), int'($urandom_range(0, 16)) - 8);
        endcase
      end
      coef_commit = ($urandom_range(0, 11) == 0);
      reset = ($urandom_range(0, 149) == 0);
      step();
    end
    idle(20);
    done = 1'b1;
  end
endmodule
